// File: rtl/fixed_divide_seq.sv
// Sequential signed fixed-point divider: quotient = round((dividend << FRAC_BITS) / divisor).
// Restoring division on magnitudes, BITS_PER_CYCLE quotient bits per cycle, valid/ready on both
// sides, tag passthrough, saturation to MAX/MIN and divide-by-zero flagging.
module fixed_divide_seq #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FRAC_BITS      = 10,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned ROUND          = 1,
  parameter int unsigned TAG_WIDTH      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  sat,
  output logic                  dbz,
  output logic                  busy
);

  localparam int unsigned NumW = DATA_WIDTH + FRAC_BITS + 1;
  localparam int unsigned Iter = (NumW + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int unsigned PadW = Iter * BITS_PER_CYCLE;
  // Remainder stays below |divisor| <= 2^(DATA_WIDTH-1); one extra bit covers the shift-in.
  localparam int unsigned RemW = DATA_WIDTH + 1;
  localparam int unsigned CntW = $clog2(Iter + 1);

  localparam logic [CntW-1:0]       CntInit = CntW'(Iter - 1);
  localparam logic [DATA_WIDTH-1:0] QMax    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] QMin    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [PadW-1:0]       MagMax  = PadW'(QMax);
  localparam logic [PadW-1:0]       MagMin  = PadW'(QMin);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic                  rdy_q;
  logic                  sign_q, sign_d;
  logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [PadW-1:0]       num_q, num_d;
  logic [RemW-1:0]       rem_q, rem_d;
  logic [PadW-1:0]       quo_q, quo_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
  logic                  sat_q, sat_d;
  logic                  dbz_q, dbz_d;

  logic [DATA_WIDTH-1:0] abs_dvd, abs_dvs;
  logic [PadW-1:0]       num_init;
  logic [RemW-1:0]       rem_w, rem_t;
  logic [PadW-1:0]       num_w, quo_w;
  logic [DATA_WIDTH-1:0] q_fmt;
  logic                  sat_fmt;

  // Magnitudes; the most negative input negates to 2^(DATA_WIDTH-1) as an unsigned value.
  assign abs_dvd = dividend[DATA_WIDTH-1] ? (~dividend + DATA_WIDTH'(1)) : dividend;
  assign abs_dvs = divisor[DATA_WIDTH-1]  ? (~divisor + DATA_WIDTH'(1))  : divisor;

  // Scaled numerator with optional half-divisor bias for round-half-away-from-zero.
  always_comb begin
    num_init = PadW'(abs_dvd) << FRAC_BITS;
    if (ROUND != 0) begin
      num_init = num_init + PadW'(abs_dvs >> 1);
    end
  end

  // Chained restoring steps for one CALC cycle, numerator consumed MSB first.
  always_comb begin
    rem_w = rem_q;
    num_w = num_q;
    quo_w = quo_q;
    rem_t = '0;
    for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
      rem_t = {rem_w[RemW-2:0], num_w[PadW-1]};
      num_w = num_w << 1;
      if (rem_t >= {1'b0, dvsr_q}) begin
        rem_w = rem_t - {1'b0, dvsr_q};
        quo_w = {quo_w[PadW-2:0], 1'b1};
      end else begin
        rem_w = rem_t;
        quo_w = {quo_w[PadW-2:0], 1'b0};
      end
    end
  end

  // Apply sign and clamp the final magnitude into the signed output range.
  always_comb begin
    sat_fmt = 1'b0;
    q_fmt   = sign_q ? (~quo_w[DATA_WIDTH-1:0] + DATA_WIDTH'(1)) : quo_w[DATA_WIDTH-1:0];
    if (!sign_q && (quo_w > MagMax)) begin
      q_fmt   = QMax;
      sat_fmt = 1'b1;
    end else if (sign_q && (quo_w > MagMin)) begin
      q_fmt   = QMin;
      sat_fmt = 1'b1;
    end
  end

  // Next-state and datapath update for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    dvsr_d     = dvsr_q;
    num_d      = num_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    quotient_d = quotient_q;
    sat_d      = sat_q;
    dbz_d      = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && rdy_q) begin
          sign_d = dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
          dvsr_d = abs_dvs;
          num_d  = num_init;
          rem_d  = '0;
          quo_d  = '0;
          cnt_d  = CntInit;
          tag_d  = in_tag;
          if (divisor == '0) begin
            state_d    = StDone;
            quotient_d = dividend[DATA_WIDTH-1] ? QMin : QMax;
            sat_d      = 1'b0;
            dbz_d      = 1'b1;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = rem_w;
        num_d = num_w;
        quo_d = quo_w;
        if (cnt_q == '0) begin
          state_d    = StDone;
          quotient_d = q_fmt;
          sat_d      = sat_fmt;
          dbz_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; rdy_q keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sign_q     <= 1'b0;
      dvsr_q     <= '0;
      num_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      tag_q      <= '0;
      quotient_q <= '0;
      sat_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      sign_q     <= sign_d;
      dvsr_q     <= dvsr_d;
      num_q      <= num_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      quotient_q <= quotient_d;
      sat_q      <= sat_d;
      dbz_q      <= dbz_d;
    end
  end

  assign in_ready  = rdy_q && (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign quotient  = quotient_q;
  assign out_tag   = tag_q;
  assign sat       = sat_q;
  assign dbz       = dbz_q;

endmodule
